// File: rtl/spdif_encoder_pkg.sv
// rtl/spdif_encoder_pkg.sv - shared constants, state type and preamble selection for the S/PDIF transmitter
package spdif_encoder_pkg;

  // Preamble UI patterns for a preceding line level of 0, first UI in the MSB
  localparam logic [7:0] PRE_B = 8'b1110_1000;
  localparam logic [7:0] PRE_M = 8'b1110_0010;
  localparam logic [7:0] PRE_W = 8'b1110_0100;

  localparam int SPDIF_SLOTS  = 32;
  localparam int CS_BLOCK_LEN = 192;
  localparam int PREAMBLE_UI  = 8;
  localparam int AUDIO_SLOTS  = 24;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA
  } spdif_tx_state_t;

  // B opens a channel-status block, M opens every other left subframe, W is right
  function automatic logic [7:0] select_preamble(input logic right, input logic block_first);
    if (right) begin
      return PRE_W;
    end else if (block_first) begin
      return PRE_B;
    end else begin
      return PRE_M;
    end
  endfunction

endpackage

// File: rtl/spdif_bmc_line.sv
// rtl/spdif_bmc_line.sv - biphase-mark line coder owning the line level and tx output
module spdif_bmc_line (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic ui_tick_i,
  input  logic is_preamble_i,
  input  logic pre_bit_i,
  input  logic data_bit_i,
  input  logic ui_phase_i,
  output logic tx_o
);

  logic level_q;
  logic tx_q;

  // Preambles are XORed onto the frozen level; data slots toggle at cell start and mid-cell for a 1
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= 1'b0;
      tx_q    <= 1'b0;
    end else if (clr_i) begin
      level_q <= 1'b0;
      tx_q    <= 1'b0;
    end else if (ui_tick_i) begin
      if (is_preamble_i) begin
        tx_q <= pre_bit_i ^ level_q;
      end else if (!ui_phase_i || data_bit_i) begin
        tx_q    <= ~level_q;
        level_q <= ~level_q;
      end
    end
  end

  assign tx_o = tx_q;

endmodule

// File: rtl/spdif_encoder.sv
// rtl/spdif_encoder.sv - S/PDIF transmitter: framing FSM, counters, parity and sample holding register
module spdif_encoder
  import spdif_encoder_pkg::*;
#(
  parameter int UI_DIV   = 4,
  parameter int SAMPLE_W = 24
) (
  input  logic                clk_in,
  input  logic                resetb,
  input  logic                ena,
  input  logic [SAMPLE_W-1:0] sample_left,
  input  logic [SAMPLE_W-1:0] sample_right,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [31:0]         cs_bits,
  output logic                tx_out,
  output logic                block_start,
  output logic                underrun
);

  localparam int         DIV_W      = $clog2(UI_DIV);
  localparam int         PAD        = AUDIO_SLOTS - SAMPLE_W;
  localparam logic [5:0] LAST_UI    = 6'(2 * SPDIF_SLOTS - 1);
  localparam logic [5:0] LAST_PRE   = 6'(PREAMBLE_UI - 1);
  localparam logic [7:0] LAST_FRAME = 8'(CS_BLOCK_LEN - 1);

  spdif_tx_state_t state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic [5:0]       ui_q;
  logic             right_q;
  logic [7:0]       frame_q;
  logic [23:0]      hold_l_q, hold_r_q, aud_l_q, aud_r_q;
  logic             full_q, v_q, par_q, block_q, underrun_q;

  logic        ui_tick, emit, is_pre, frame_start, accept, data_bit, pre_bit;
  logic [4:0]  slot;
  logic [23:0] cur_aud;
  logic [7:0]  pattern;

  assign ui_tick     = ena && (div_q == DIV_W'(UI_DIV - 1));
  assign emit        = ui_tick && (state_q != IDLE);
  assign is_pre      = (state_q == PREAMBLE);
  assign frame_start = emit && is_pre && (ui_q == 6'd0) && !right_q;
  assign accept      = sample_valid && !full_q;
  assign slot        = ui_q[5:1];
  assign cur_aud     = right_q ? aud_r_q : aud_l_q;
  assign pattern     = select_preamble(right_q, frame_q == 8'd0);
  assign pre_bit     = pattern[3'd7 - ui_q[2:0]];

  // Bit carried by the current data slot: audio LSB first, then V, U, C, P
  always_comb begin
    data_bit = 1'b0;
    case (slot)
      5'd28:   data_bit = v_q;
      5'd29:   data_bit = 1'b0;
      5'd30:   data_bit = (frame_q < 8'd32) ? cs_bits[frame_q[4:0]] : 1'b0;
      5'd31:   data_bit = par_q;
      default: if (slot >= 5'd4) data_bit = cur_aud[slot - 5'd4];
    endcase
  end

  // Framing next state; dropping ena always returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (ui_tick) state_d = PREAMBLE;
      PREAMBLE: if (emit && ui_q == LAST_PRE) state_d = DATA;
      DATA:     if (emit && ui_q == LAST_UI) state_d = PREAMBLE;
      default:  state_d = IDLE;
    endcase
    if (!ena) state_d = IDLE;
  end

  // Framing state register
  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // UI divider, subframe/frame position and running parity, cleared while disabled
  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      div_q   <= '0;
      ui_q    <= 6'd0;
      right_q <= 1'b0;
      frame_q <= 8'd0;
      par_q   <= 1'b0;
    end else if (!ena) begin
      div_q   <= '0;
      ui_q    <= 6'd0;
      right_q <= 1'b0;
      frame_q <= 8'd0;
      par_q   <= 1'b0;
    end else begin
      div_q <= ui_tick ? '0 : div_q + 1'b1;
      if (emit) begin
        ui_q <= ui_q + 6'd1;
        if (ui_q == LAST_UI) begin
          right_q <= !right_q;
          if (right_q) frame_q <= (frame_q == LAST_FRAME) ? 8'd0 : frame_q + 8'd1;
        end
        if (is_pre) begin
          par_q <= 1'b0;
        end else if (!ui_q[0] && slot != 5'd31) begin
          par_q <= par_q ^ data_bit;
        end
      end
    end
  end

  // One-deep holding register; a load in the accept cycle still sees it empty
  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      hold_l_q <= 24'd0;
      hold_r_q <= 24'd0;
      full_q   <= 1'b0;
    end else if (accept) begin
      hold_l_q <= 24'(sample_left) << PAD;
      hold_r_q <= 24'(sample_right) << PAD;
      full_q   <= 1'b1;
    end else if (frame_start && full_q) begin
      full_q <= 1'b0;
    end
  end

  // Frame loader at the first UI of each left preamble, plus block/underrun pulses
  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      aud_l_q    <= 24'd0;
      aud_r_q    <= 24'd0;
      v_q        <= 1'b0;
      block_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      block_q    <= frame_start && (frame_q == 8'd0);
      underrun_q <= frame_start && !full_q;
      if (frame_start) begin
        aud_l_q <= full_q ? hold_l_q : 24'd0;
        aud_r_q <= full_q ? hold_r_q : 24'd0;
        v_q     <= !full_q;
      end
    end
  end

  spdif_bmc_line u_line (
    .clk_i        (clk_in),
    .rst_ni       (resetb),
    .clr_i        (!ena),
    .ui_tick_i    (emit),
    .is_preamble_i(is_pre),
    .pre_bit_i    (pre_bit),
    .data_bit_i   (data_bit),
    .ui_phase_i   (ui_q[0]),
    .tx_o         (tx_out)
  );

  assign sample_ready = !full_q;
  assign block_start  = block_q;
  assign underrun     = underrun_q;

endmodule

// File: doc/spdif_encoder.md
Name: spdif_encoder

Overview:
- S/PDIF (IEC 60958) transmitter; the transmit-side counterpart of spdif_decoder in the amplifier interface.
- Accepts stereo PCM sample pairs over a valid/ready handshake and builds 192-frame channel-status blocks.
- Emits a biphase-mark-coded line on tx_out for loopback testing of the receive path and for driving an external S/PDIF sink.

Parameters:
- UI_DIV, 4, clk_in cycles per unit interval (half bit-cell); legal range >= 2. The value 4 gives 48 kHz at a 24.576 MHz clk_in.
- SAMPLE_W, 24, audio word width; legal range 16..24. Unused LSB slots are sent as 0.

Ports:
- clk_in  in  1  system clock
- resetb  in  1  asynchronous active-low reset
- ena  in  1  transmit enable
- sample_left  in  SAMPLE_W  left PCM, two's complement
- sample_right  in  SAMPLE_W  right PCM
- sample_valid  in  1  sample pair offered
- sample_ready  out  1  holding register empty; transfer occurs when valid&&ready
- cs_bits  in  32  channel-status bits 0..31; bits 32..191 are sent as 0; the same value is used for both channels
- tx_out  out  1  BMC line output
- block_start  out  1  one-cycle pulse at the first UI of preamble B
- underrun  out  1  one-cycle pulse when a frame starts with the holding register empty

Behaviour:
- Reset values: tx_out=0, sample_ready=1, block_start=0, underrun=0; all counters 0; FSM=IDLE; line level register=0.
- UI tick: a divider counts 0..UI_DIV-1 and ticks at UI_DIV-1. tx_out is registered and changes only on the cycle after a tick.
- Frame and slot structure:
  - 1 frame = 2 subframes, 1 subframe = 32 slots, 1 slot = 2 UI, so 1 frame = 128 UI.
  - Slots 0-3: preamble (8 UI).
  - Slots 4-27: audio, LSB first, MSB in slot 27. For SAMPLE_W<24 the sample is left-justified to slot 27.
  - Slot 28: V. V=0 normally, V=1 in underrun frames.
  - Slot 29: U=0.
  - Slot 30: C = cs_bits[frame_cnt] when frame_cnt<32, else 0.
  - Slot 31: P = even parity over slots 4-30.
- BMC coding: each data slot toggles the level at its first UI, and toggles again at its second UI iff the bit is 1.
- Preambles: 8-UI patterns defined for a preceding level of 0, each UI output as pattern XOR level-before-preamble.
  - B = 11101000 (left subframe, frame_cnt=0).
  - M = 11100010 (left subframe, other frames).
  - W = 11100100 (right subframe).
  - The level after a preamble equals the level before it.
- FSM: IDLE -> PREAMBLE -> DATA -> PREAMBLE ...
  - IDLE -> PREAMBLE on the first tick with ena=1. Start at frame_cnt=0, left subframe.
  - PREAMBLE -> DATA after 8 UI.
  - DATA -> PREAMBLE after slot 31.
  - The subframe toggles left/right at each DATA->PREAMBLE; frame_cnt increments after the right subframe and wraps 191 -> 0.
- Holding register (1-deep):
  - Accept when sample_valid && sample_ready. sample_ready drops the next cycle.
  - At the first UI of every left preamble:
    - If the register is full: move left/right into the shift registers and clear the register, so sample_ready=1 next cycle.
    - If empty: load zeros for both channels, set V=1 in both subframes of that frame, and pulse underrun.
  - Simultaneous accept and frame-start load in the same cycle: the load sees the register empty (underrun). The accepted pair is kept for the next frame.
- ena deasserted mid-frame:
  - On the next cycle: FSM=IDLE, tx_out=0, level register=0, divider/slot/frame counters cleared.
  - The holding register contents and sample_ready are kept.
- Latency: a pair accepted at least 1 cycle before a left-preamble start is transmitted in that frame; slot 4 begins 8 UI later.
- Asserting resetb mid-operation behaves like reset at any time: all state returns to its reset value immediately.

Decomposition:
- toi2s_pkg additions:
  - Preamble constants PRE_B, PRE_M, PRE_W (8 bits each).
  - SPDIF_SLOTS=32 and CS_BLOCK_LEN=192.
  - typedef enum spdif_tx_state_t {IDLE, PREAMBLE, DATA}.
- One sub-module, spdif_bmc_line:
  - Inputs: ui_tick, is_preamble, preamble pattern bit, data bit, ui phase.
  - Owns the level register and tx_out.
- The framing FSM, counters, parity and holding register stay in spdif_encoder.

Test Plan:
- Reset/idle: resetb low, then ena=0 for 1000 cycles -> tx_out=0, sample_ready=1, no pulses.
- Framing (UI_DIV=4, ena rising):
  - block_start pulses once.
  - tx_out follows B=11101000, each UI 4 cycles wide.
  - block_start repeats every 192*512 = 98304 cycles.
  - M and W appear in place of B on the other frames.
- Data and parity: left=24'h000001, right=24'h800000, cs_bits=0 -> left slot 4=1, P=1; right slot 27=1, P=1; V=0, no underrun.
- Channel status: cs_bits=32'h00000004 -> slot 30 is 1 only in frame 2 (both subframes) and 0 in frames 0,1,3..191.
- Underrun: stop sample_valid -> next frame has V=1, audio 0, one underrun pulse per frame; resuming valid clears V on the following frame.
- Loopback: tx_out into spdif_decoder with a ramp input -> audio_locked=1 and i2s_d0 words match the ramp. Dropping ena mid-subframe -> tx_out=0 the next cycle, and the restart begins with preamble B.
